// File: rtl/dmem_pkg.sv
// Shared definitions for the data-memory load/store unit: funct3 encodings,
// FSM state encoding and small decode helpers used by the top and the bench.
package dmem_pkg;

   localparam logic [2:0] F3_B  = 3'b000;
   localparam logic [2:0] F3_H  = 3'b001;
   localparam logic [2:0] F3_W  = 3'b010;
   localparam logic [2:0] F3_BU = 3'b100;
   localparam logic [2:0] F3_HU = 3'b101;

   typedef enum logic [0:0] {
      ST_IDLE  = 1'b0,
      ST_BEAT2 = 1'b1
   } state_e;

   // Access size in bytes; 0 marks an encoding that is not a legal load/store size.
   function automatic logic [2:0] size_bytes(input logic [2:0] f3);
      case (f3)
         F3_B, F3_BU: size_bytes = 3'd1;
         F3_H, F3_HU: size_bytes = 3'd2;
         F3_W:        size_bytes = 3'd4;
         default:     size_bytes = 3'd0;
      endcase
   endfunction

   // True when the last byte of the access falls into the next word.
   function automatic logic crosses_word(input logic [1:0] offset, input logic [2:0] size);
      logic [3:0] end_s;
      end_s = {2'b00, offset} + {1'b0, size};
      crosses_word = (end_s > 4'd4);
   endfunction

   // Byte-lane mask of an access before it is shifted to its offset.
   function automatic logic [3:0] size_mask(input logic [2:0] size);
      case (size)
         3'd1:    size_mask = 4'b0001;
         3'd2:    size_mask = 4'b0011;
         3'd4:    size_mask = 4'b1111;
         default: size_mask = 4'b0000;
      endcase
   endfunction

   // Sign/zero extension of LSB-aligned raw load data.
   function automatic logic [31:0] extend_load(input logic [2:0] f3, input logic [31:0] raw);
      case (f3)
         F3_B:    extend_load = {{24{raw[7]}}, raw[7:0]};
         F3_H:    extend_load = {{16{raw[15]}}, raw[15:0]};
         F3_W:    extend_load = raw;
         F3_BU:   extend_load = {24'h000000, raw[7:0]};
         F3_HU:   extend_load = {16'h0000, raw[15:0]};
         default: extend_load = 32'h0000_0000;
      endcase
   endfunction

endpackage

// File: rtl/dmem_bank.sv
// Word-organised RAM with per-byte write enables and a registered read port.
// Contents are deliberately not reset.
module dmem_bank #(
   parameter int unsigned WORDS = 256,
   parameter int unsigned IDX_W = 8
) (
   input  logic             clk_i,
   input  logic [IDX_W-1:0] idx_i,
   input  logic [3:0]       be_i,
   input  logic [31:0]      wdata_i,
   input  logic             re_i,
   output logic [31:0]      rdata_o
);

   logic [31:0] mem_q [WORDS];
   logic [31:0] rdata_q;

   // Byte-lane writes and a read that only updates when requested, so the
   // read register keeps the last loaded word between loads.
   always_ff @(posedge clk_i) begin
      for (int k = 0; k < 4; k++) begin
         if (be_i[k]) begin
            mem_q[idx_i][8*k +: 8] <= wdata_i[8*k +: 8];
         end
      end
      if (re_i) begin
         rdata_q <= mem_q[idx_i];
      end
   end

   assign rdata_o = rdata_q;

endmodule

// File: rtl/dmem_lsu.sv
// Load/store unit in front of a byte-lane data RAM. Accepts one request per
// cycle, checks it for faults, steers store lanes, splits word-crossing
// accesses into two aligned beats (when enabled) and extends load data.
module dmem_lsu
   import dmem_pkg::*;
#(
   parameter int unsigned DEPTH_BYTES      = 1024,
   parameter int unsigned ADDR_WIDTH       = 10,
   parameter bit          SPLIT_MISALIGNED = 1'b1
) (
   input  logic        CLK,
   input  logic        RST,
   input  logic        REQ_VALID,
   output logic        REQ_READY,
   input  logic        WE,
   input  logic [2:0]  funct3,
   input  logic [31:0] ADDRESS,
   input  logic [31:0] WRITE_DATA,
   output logic        RSP_VALID,
   output logic [31:0] READ_DATA,
   output logic        FAULT
);

   localparam int unsigned WORDS = DEPTH_BYTES / 4;
   localparam int unsigned IDX_W = ADDR_WIDTH - 2;
   localparam logic [IDX_W-1:0] LAST_IDX = {IDX_W{1'b1}};
   localparam logic [IDX_W-1:0] ONE_IDX  = {{(IDX_W-1){1'b0}}, 1'b1};

   state_e state_q, state_d;

   // request decode
   logic [2:0]       size_s;
   logic [1:0]       off_s;
   logic [IDX_W-1:0] idx_s;
   logic             illegal_s, range_s, cross_s, fault_s, accept_s;
   logic [7:0]       be_wide_s;
   logic [63:0]      wdata_wide_s;

   // bank interface
   logic [IDX_W-1:0] bank_idx_s;
   logic [3:0]       bank_be_s;
   logic [31:0]      bank_wdata_s;
   logic             bank_re_s;
   logic [31:0]      bank_rdata_s;

   // second-beat context
   logic [IDX_W-1:0] b2_idx_q;
   logic [3:0]       b2_be_q;
   logic [31:0]      b2_wdata_q;
   logic             b2_we_q;

   // response context
   logic             rsp_valid_q, fault_q, zero_q, split_q;
   logic [2:0]       f3_q;
   logic [1:0]       off_q;
   logic [31:0]      hold_q, rd_hold_q;
   logic [63:0]      merged_s;
   logic [31:0]      raw_s, fmt_s, read_data_s;

   assign REQ_READY = (state_q == ST_IDLE) && !RST;
   assign accept_s  = REQ_VALID && REQ_READY;

   // Decode size, alignment and fault conditions of the presented request.
   always_comb begin
      size_s    = size_bytes(funct3);
      off_s     = ADDRESS[1:0];
      idx_s     = ADDRESS[ADDR_WIDTH-1:2];
      illegal_s = (size_s == 3'd0) || (WE && funct3[2]);
      range_s   = |ADDRESS[31:ADDR_WIDTH];
      cross_s   = crosses_word(off_s, size_s);
      // A crossing access in the last word would need a beat past the end of memory.
      fault_s   = illegal_s || range_s ||
                  (cross_s && ((SPLIT_MISALIGNED == 1'b0) || (idx_s == LAST_IDX)));
      be_wide_s    = {4'b0000, size_mask(size_s)} << off_s;
      wdata_wide_s = {32'h0000_0000, WRITE_DATA} << {off_s, 3'b000};
   end

   // FSM state register.
   always_ff @(posedge CLK) begin
      if (RST) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next state and bank control: beat 1 at the accept edge, beat 2 from held context.
   always_comb begin
      state_d      = state_q;
      bank_idx_s   = idx_s;
      bank_be_s    = 4'b0000;
      bank_wdata_s = wdata_wide_s[31:0];
      bank_re_s    = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (accept_s && !fault_s) begin
               bank_be_s = WE ? be_wide_s[3:0] : 4'b0000;
               bank_re_s = !WE;
               if (cross_s) begin
                  state_d = ST_BEAT2;
               end else begin
                  state_d = ST_IDLE;
               end
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_BEAT2: begin
            bank_idx_s   = b2_idx_q;
            bank_wdata_s = b2_wdata_q;
            // Reset during the second beat drops it; the first beat already happened.
            if (RST) begin
               bank_be_s = 4'b0000;
               bank_re_s = 1'b0;
            end else begin
               bank_be_s = b2_we_q ? b2_be_q : 4'b0000;
               bank_re_s = !b2_we_q;
            end
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // Capture the upper-word half of a crossing access for the second beat.
   always_ff @(posedge CLK) begin
      if (RST) begin
         b2_idx_q   <= {IDX_W{1'b0}};
         b2_be_q    <= 4'b0000;
         b2_wdata_q <= 32'h0000_0000;
         b2_we_q    <= 1'b0;
      end else if ((state_q == ST_IDLE) && accept_s && !fault_s && cross_s) begin
         b2_idx_q   <= idx_s + ONE_IDX;
         b2_be_q    <= be_wide_s[7:4];
         b2_wdata_q <= wdata_wide_s[63:32];
         b2_we_q    <= WE;
      end else begin
         b2_idx_q   <= b2_idx_q;
         b2_be_q    <= b2_be_q;
         b2_wdata_q <= b2_wdata_q;
         b2_we_q    <= b2_we_q;
      end
   end

   // Response flags and load formatting context.
   always_ff @(posedge CLK) begin
      if (RST) begin
         rsp_valid_q <= 1'b0;
         fault_q     <= 1'b0;
         zero_q      <= 1'b1;
         split_q     <= 1'b0;
         f3_q        <= F3_W;
         off_q       <= 2'b00;
         rd_hold_q   <= 32'h0000_0000;
      end else begin
         rd_hold_q <= read_data_s;
         if (state_q == ST_BEAT2) begin
            rsp_valid_q <= 1'b1;
            fault_q     <= 1'b0;
            zero_q      <= b2_we_q;
            split_q     <= 1'b1;
         end else if (accept_s) begin
            rsp_valid_q <= fault_s || !cross_s;
            fault_q     <= fault_s;
            zero_q      <= fault_s || WE;
            split_q     <= 1'b0;
            f3_q        <= funct3;
            off_q       <= off_s;
         end else begin
            rsp_valid_q <= 1'b0;
            fault_q     <= 1'b0;
         end
      end
   end

   // Hold the low word read by beat 1 while beat 2 reads the next word.
   always_ff @(posedge CLK) begin
      if (RST) begin
         hold_q <= 32'h0000_0000;
      end else if (state_q == ST_BEAT2) begin
         hold_q <= bank_rdata_s;
      end else begin
         hold_q <= hold_q;
      end
   end

   // Merge beats, shift to LSB, extend; hold the last value between responses.
   always_comb begin
      if (split_q) begin
         merged_s = {bank_rdata_s, hold_q};
      end else begin
         merged_s = {32'h0000_0000, bank_rdata_s};
      end
      raw_s = merged_s[{off_q, 3'b000} +: 32];
      if (zero_q) begin
         fmt_s = 32'h0000_0000;
      end else begin
         fmt_s = extend_load(f3_q, raw_s);
      end
      if (rsp_valid_q) begin
         read_data_s = fmt_s;
      end else begin
         read_data_s = rd_hold_q;
      end
   end

   assign RSP_VALID = rsp_valid_q;
   assign FAULT     = fault_q;
   assign READ_DATA = read_data_s;

   dmem_bank #(
      .WORDS (WORDS),
      .IDX_W (IDX_W)
   ) u_bank (
      .clk_i   (CLK),
      .idx_i   (bank_idx_s),
      .be_i    (bank_be_s),
      .wdata_i (bank_wdata_s),
      .re_i    (bank_re_s),
      .rdata_o (bank_rdata_s)
   );

endmodule
